bus_reader12: RTL and testbench

Receiving end of the shared 12-bit tri-state data bus. The block arbitrates among up to NSRC bus sources and issues a one-hot drive enable to the `ctrl` input of exactly one `tri12` driver. It samples the resolved bus in the cycle that enable is high and queues each word, tagged with its source index, in a small FIFO. Downstream logic reads the FIFO through a valid/ready handshake. This block is the only place that decides who drives the bus, which guarantees no bus contention.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/bus_reader12.sv | 140 ++++++++++++++
 tb/tb_bus_reader12.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ============================================================================
// bus_pkg : shared types and defaults for the 12-bit tri-state bus reader
// Rev 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

   localparam int BUS_W     = 12;
   localparam int NSRC_DEF  = 4;
   localparam int DEPTH_DEF = 4;

   typedef logic [BUS_W-1:0] bus_word_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin pick of the first requester after last_gnt
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last_gnt,
   input  logic                 grant_en,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 any_req
);

   localparam int IW = $clog2(N);

   logic          w_found;
   logic [31:0]   w_cand;
   logic [IW-1:0] w_idx;

   // Search order is last_gnt+1, last_gnt+2, ... wrapping modulo N.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cand  = '0;
      for (int k = 1; k <= N; k++) begin
         w_cand = (32'(last_gnt) + 32'(k)) % 32'(N);
         if (!w_found && req[w_cand[IW-1:0]]) begin
            w_found = 1'b1;
            w_idx   = w_cand[IW-1:0];
         end
      end
   end

   assign any_req = |req;
   assign gnt_idx = grant_en ? w_idx : '0;

endmodule

`default_nettype wire

// File: rtl/bus_reader12.sv
// ============================================================================
// bus_reader12 : sole owner of the shared 12-bit bus; grants one driver per
//                cycle and queues the sampled word with its source index
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_reader12
   import bus_pkg::*;
#(
   parameter int NSRC  = NSRC_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NSRC-1:0]         req,
   output logic [NSRC-1:0]         en,
   input  logic [BUS_W-1:0]        bus,
   output logic [BUS_W-1:0]        out_data,
   output logic [$clog2(NSRC)-1:0] out_src,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    full,
   output logic                    empty
);

   localparam int SW = $clog2(NSRC);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [NSRC-1:0] r_en;
   logic [NSRC-1:0] w_en_nxt;
   logic [SW-1:0]   r_last_gnt;
   logic [SW-1:0]   w_gnt_idx;
   logic            w_any_req;
   logic            w_room;
   logic            w_grant;
   logic            w_push;
   logic            w_pop;

   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic            r_full;
   logic            r_empty;
   logic            r_valid;
   bus_word_t       r_mem_data [DEPTH];
   logic [SW-1:0]   r_mem_src  [DEPTH];

   // The word being transferred still occupies a slot; a same-cycle pop is
   // deliberately not credited.
   assign w_room  = (32'(r_count) + ((r_state == XFER) ? 32'd1 : 32'd0)) < 32'(DEPTH);
   assign w_grant = w_any_req && w_room;

   rr_arbiter #(
      .N (NSRC)
   ) u_arb (
      .req      (req),
      .last_gnt (r_last_gnt),
      .grant_en (w_room),
      .gnt_idx  (w_gnt_idx),
      .any_req  (w_any_req)
   );

   always_comb begin
      w_state_nxt = IDLE;
      w_en_nxt    = '0;
      case (r_state)
         IDLE, XFER: begin
            if (w_grant) begin
               w_state_nxt = XFER;
               w_en_nxt    = NSRC'(1) << w_gnt_idx;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_en       <= '0;
         r_last_gnt <= SW'(NSRC - 1);
      end else begin
         r_state <= w_state_nxt;
         r_en    <= w_en_nxt;
         if (w_grant) begin
            r_last_gnt <= w_gnt_idx;
         end
      end
   end

   // While in XFER, r_last_gnt is the index of the source currently driving.
   assign w_push      = (r_state == XFER);
   assign w_pop       = r_valid && out_ready;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_valid  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_src[i]  <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus;
            r_mem_src[r_wr_ptr]  <= r_last_gnt;
            r_wr_ptr             <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
         r_valid <= (w_count_nxt != '0);
      end
   end

   assign en        = r_en;
   assign out_data  = r_mem_data[r_rd_ptr];
   assign out_src   = r_mem_src[r_rd_ptr];
   assign out_valid = r_valid;
   assign full      = r_full;
   assign empty     = r_empty;

   a_no_push_when_full: assert property (@(posedge clock) disable iff (reset) !(w_push && r_full));

endmodule

`default_nettype wire

// File: tb/tb_bus_reader12.sv
// ============================================================================
// tb_bus_reader12 : table-driven and scoreboard checks for bus_reader12
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_reader12;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [3:0]  en;
   logic [11:0] bus;
   logic [11:0] out_data;
   logic [1:0]  out_src;
   logic        out_valid;
   logic        out_ready;
   logic        full;
   logic        empty;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic        use_fixed;
   logic [11:0] fixed_word;
   logic [13:0] sb_q [$];

   typedef struct packed {
      logic [3:0] req;
      logic       rdy;
      logic [3:0] en;
      logic       v;
      logic       f;
      logic       e;
   } vec_t;

   vec_t tbl [$];

   always #5 clock = ~clock;

   bus_reader12 #(
      .NSRC  (4),
      .DEPTH (4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .en        (en),
      .bus       (bus),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (full),
      .empty     (empty)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Settles the current cycle into the scoreboard, advances one clock and
   // models the granted tri12 driver onto the bus.
   task automatic tick();
      logic [13:0] exp_w;
      logic [1:0]  idx;
      if (reset) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: popped %0h, none expected", {out_src, out_data});
            end else begin
               exp_w = sb_q.pop_front();
               chk("sb_word", 32'({out_src, out_data}), 32'(exp_w));
            end
         end
         if (en != 4'b0000) begin
            idx = 2'd0;
            for (int i = 0; i < 4; i++) if (en[i]) idx = 2'(i);
            sb_q.push_back({idx, bus});
         end
      end
      @(posedge clock);
      #1;
      cyc++;
      chk("en_onehot0", 32'($onehot0(en)), 32'd1);
      if (en == 4'b0000)  bus = 12'hFFF;
      else if (use_fixed) bus = fixed_word;
      else                bus = {en, cyc[7:0]};
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req       = 4'b0000;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_en",    32'(en),        32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data",  32'(out_data),  32'h0);
      chk("rst_src",   32'(out_src),   32'h0);
      chk("rst_full",  32'(full),      32'h0);
      chk("rst_empty", 32'(empty),     32'h1);
      reset = 1'b0;
   endtask

   task automatic run_table(input string name);
      for (int k = 0; k < tbl.size(); k++) begin
         req       = tbl[k].req;
         out_ready = tbl[k].rdy;
         tick();
         chk($sformatf("%s[%0d].en", name, k),    32'(en),        32'(tbl[k].en));
         chk($sformatf("%s[%0d].valid", name, k), 32'(out_valid), 32'(tbl[k].v));
         chk($sformatf("%s[%0d].full", name, k),  32'(full),      32'(tbl[k].f));
         chk($sformatf("%s[%0d].empty", name, k), 32'(empty),     32'(tbl[k].e));
      end
      tbl.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      req        = 4'b0000;
      out_ready  = 1'b0;
      bus        = 12'hFFF;
      use_fixed  = 1'b0;
      fixed_word = 12'h000;

      // Single source, fixed bus word
      do_reset();
      use_fixed  = 1'b1;
      fixed_word = 12'h5A3;
      req        = 4'b0001;
      tick();
      chk("t1_en", 32'(en), 32'h1);
      req = 4'b0000;
      tick();
      chk("t1_en_off", 32'(en),        32'h0);
      chk("t1_valid",  32'(out_valid), 32'h1);
      chk("t1_data",   32'(out_data),  32'h5A3);
      chk("t1_src",    32'(out_src),   32'h0);
      out_ready = 1'b1;
      tick();
      chk("t1_empty", 32'(empty), 32'h1);
      use_fixed = 1'b0;
      out_ready = 1'b0;

      // All four sources, consumer always ready
      do_reset();
      tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1});
      run_table("rr");

      // Stalled consumer: fill to DEPTH, then one pop frees one grant
      tbl.push_back('{4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0});
      run_table("full");

      // Push and pop together at count 2, six words across the pointer wrap
      do_reset();
      req = 4'b0010;
      tick();
      chk("pp_en1", 32'(en), 32'h2);
      tick();
      chk("pp_en2", 32'(en), 32'h2);
      tick();
      chk("pp_en3",    32'(en),        32'h2);
      chk("pp_valid3", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      for (int k = 4; k <= 6; k++) begin
         tick();
         chk($sformatf("pp_en%0d", k),    32'(en),    32'h2);
         chk($sformatf("pp_full%0d", k),  32'(full),  32'h0);
         chk($sformatf("pp_empty%0d", k), 32'(empty), 32'h0);
      end
      req = 4'b0000;
      tick();
      chk("pp_en7",    32'(en),        32'h0);
      chk("pp_valid7", 32'(out_valid), 32'h1);
      tick();
      chk("pp_valid8", 32'(out_valid), 32'h1);
      tick();
      chk("pp_empty9",   32'(empty),       32'h1);
      chk("pp_sb_drain", 32'(sb_q.size()), 32'h0);
      out_ready = 1'b0;

      // Reset in the en-high cycle with a word already queued
      req = 4'b0100;
      tick();
      chk("rm_en1", 32'(en), 32'h4);
      tick();
      chk("rm_en2",    32'(en),        32'h4);
      chk("rm_valid2", 32'(out_valid), 32'h1);
      reset = 1'b1;
      req   = 4'b1010;
      tick();
      chk("rm_en3",    32'(en),        32'h0);
      chk("rm_empty3", 32'(empty),     32'h1);
      chk("rm_valid3", 32'(out_valid), 32'h0);
      chk("rm_full3",  32'(full),      32'h0);
      chk("rm_data3",  32'(out_data),  32'h0);
      reset = 1'b0;
      tick();
      chk("rm_first_gnt", 32'(en), 32'h2);

      // Requester drops in its own en-high cycle
      req       = 4'b0000;
      out_ready = 1'b1;
      tick();
      chk("dr_en5",    32'(en),        32'h0);
      chk("dr_valid5", 32'(out_valid), 32'h1);
      chk("dr_src5",   32'(out_src),   32'h1);
      tick();
      chk("dr_en6",    32'(en),    32'h0);
      chk("dr_empty6", 32'(empty), 32'h1);
      tick();
      chk("dr_en7", 32'(en), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
